// File: rtl/cntr_mod.sv
// rtl/cntr_mod.sv - parametrised modulo up/down counter with load, wrap pulse and optional enable prescaler (CNTR_MOD_PRESCALE_EN)
module cntr_mod #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    // Reject illegal parameter combinations at elaboration time.
    generate
        if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
            $error("cntr_mod: WIDTH must be 1..16");
        end
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
            $error("cntr_mod: MODULUS must be 2..2**WIDTH");
        end
        if (PRESCALE < 1 || PRESCALE > 65536) begin : g_bad_prescale
            $error("cntr_mod: PRESCALE must be 1..65536");
        end
    endgenerate

    // Terminal count value, expressed in the counter's own width.
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             w_step;
    logic [WIDTH-1:0] w_load_clamped;

    assign count = r_count;
    assign wrap  = r_wrap;

    // Out-of-range load values saturate at the terminal count.
    assign w_load_clamped = (load_val > MAX_CNT) ? MAX_CNT : load_val;

`ifdef CNTR_MOD_PRESCALE_EN
    // The divider spans up to 65536 phases, so 16 bits always suffice.
    localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

    logic [15:0] r_pre;

    // A step fires only on the enabled cycle that completes a prescale period.
    assign w_step = en && (r_pre == PRE_MAX);

    // Prescale phase: cleared by reset and load, frozen while en is low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pre <= '0;
        end else if (load) begin
            r_pre <= '0;
        end else if (en) begin
            if (w_step) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + 16'd1;
            end
        end
    end
`else
    assign w_step = en;
`endif

    // Count and wrap registers: reset > load > step > hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else if (load) begin
            r_count <= w_load_clamped;
            r_wrap  <= 1'b0;
        end else if (w_step) begin
            if (up) begin
                if (r_count == MAX_CNT) begin
                    r_count <= '0;
                    r_wrap  <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                    r_wrap  <= 1'b0;
                end
            end else begin
                if (r_count == '0) begin
                    r_count <= MAX_CNT;
                    r_wrap  <= 1'b1;
                end else begin
                    r_count <= r_count - 1'b1;
                    r_wrap  <= 1'b0;
                end
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cntr_mod.sv
// tb/tb_cntr_mod.sv - self-checking bench for cntr_mod (three instances: M10, M16, M4 with PRESCALE=3)
module tb_cntr_mod;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [3:0] count_a, count_b, count_c;
    logic       wrap_a, wrap_b, wrap_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cntr_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count_a), .wrap(wrap_a)
    );

    cntr_mod #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) u_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count_b), .wrap(wrap_b)
    );

    cntr_mod #(.WIDTH(4), .MODULUS(4), .PRESCALE(3)) u_c (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count_c), .wrap(wrap_c)
    );

    // Reference model: one entry per instance.
    int m_mod [3] = '{10, 16, 4};
`ifdef CNTR_MOD_PRESCALE_EN
    int m_psc [3] = '{1, 1, 3};
`else
    int m_psc [3] = '{1, 1, 1};
`endif
    int m_cnt [3] = '{0, 0, 0};
    int m_wrap[3] = '{0, 0, 0};
    int m_pre [3] = '{0, 0, 0};

    typedef struct {
        logic       rst;
        logic       en;
        logic       up;
        logic       load;
        logic [3:0] lv;
        int         exp_count;
        int         exp_wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic e, input logic u,
                                input logic l, input logic [3:0] lv);
        for (int i = 0; i < 3; i++) begin
            if (!r) begin
                m_cnt[i] = 0; m_wrap[i] = 0; m_pre[i] = 0;
            end else if (l) begin
                m_cnt[i]  = (int'(lv) > m_mod[i] - 1) ? m_mod[i] - 1 : int'(lv);
                m_wrap[i] = 0;
                m_pre[i]  = 0;
            end else begin
                bit stepping;
                stepping = e && (m_pre[i] == m_psc[i] - 1);
                if (e) m_pre[i] = (m_pre[i] + 1) % m_psc[i];
                if (stepping) begin
                    if (u) begin
                        m_wrap[i] = (m_cnt[i] + 1 == m_mod[i]) ? 1 : 0;
                        m_cnt[i]  = (m_cnt[i] + 1) % m_mod[i];
                    end else begin
                        m_wrap[i] = (m_cnt[i] == 0) ? 1 : 0;
                        m_cnt[i]  = (m_cnt[i] + m_mod[i] - 1) % m_mod[i];
                    end
                end else begin
                    m_wrap[i] = 0;
                end
            end
        end
    endtask

    task automatic check_models();
        check("model_a_count", int'(count_a), m_cnt[0]);
        check("model_a_wrap",  int'(wrap_a),  m_wrap[0]);
        check("model_b_count", int'(count_b), m_cnt[1]);
        check("model_b_wrap",  int'(wrap_b),  m_wrap[1]);
        check("model_c_count", int'(count_c), m_cnt[2]);
        check("model_c_wrap",  int'(wrap_c),  m_wrap[2]);
    endtask

    // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
    task automatic apply(input logic r, input logic e, input logic u,
                         input logic l, input logic [3:0] lv);
        rst = r; en = e; up = u; load = l; load_val = lv;
        @(posedge clk);
        #1;
        model_update(r, e, u, l, lv);
        check_models();
    endtask

    task automatic add_vec(input logic r, input logic e, input logic u, input logic l,
                           input logic [3:0] lv, input int ec, input int ew);
        vec_t v;
        v.rst = r; v.en = e; v.up = u; v.load = l; v.lv = lv;
        v.exp_count = ec; v.exp_wrap = ew;
        vecs.push_back(v);
    endtask

    initial begin
        // Vectors for the MODULUS=10 instance.
        add_vec(0, 1, 1, 0, 4'd0, 0, 0);
        add_vec(0, 1, 1, 0, 4'd0, 0, 0);
        for (int i = 0; i < 5; i++) add_vec(1, 0, 1, 0, 4'd0, 0, 0);
        for (int i = 1; i <= 12; i++) add_vec(1, 1, 1, 0, 4'd0, i % 10, (i == 10) ? 1 : 0);
        add_vec(1, 0, 0, 1, 4'd1, 1, 0);
        add_vec(1, 1, 0, 0, 4'd0, 0, 0);
        add_vec(1, 1, 0, 0, 4'd0, 9, 1);
        add_vec(1, 1, 1, 0, 4'd0, 0, 1);
        add_vec(1, 1, 1, 1, 4'd13, 9, 0);
        add_vec(0, 1, 1, 1, 4'd5, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].load, vecs[i].lv);
            check($sformatf("vec%0d_count", i), int'(count_a), vecs[i].exp_count);
            check($sformatf("vec%0d_wrap", i),  int'(wrap_a),  vecs[i].exp_wrap);
        end

        // Full-range roll-over on the MODULUS=16 instance.
        apply(1, 0, 1, 1, 4'd15);
        check("b_load15", int'(count_b), 15);
        apply(1, 1, 1, 0, 4'd0);
        check("b_up_roll_count", int'(count_b), 0);
        check("b_up_roll_wrap",  int'(wrap_b),  1);
        apply(1, 1, 0, 0, 4'd0);
        check("b_down_roll_count", int'(count_b), 15);
        check("b_down_roll_wrap",  int'(wrap_b),  1);

        // Prescaler sequence on the MODULUS=4 instance.
        apply(0, 0, 1, 0, 4'd0);
        for (int i = 1; i <= 12; i++) begin
            apply(1, 1, 1, 0, 4'd0);
`ifdef CNTR_MOD_PRESCALE_EN
            if (i == 2)  check("c_pre_hold", int'(count_c), 0);
            if (i == 3)  check("c_pre_first", int'(count_c), 1);
            if (i == 11) check("c_pre_nowrap", int'(wrap_c), 0);
            if (i == 12) begin
                check("c_pre_wrap_count", int'(count_c), 0);
                check("c_pre_wrap", int'(wrap_c), 1);
            end
`endif
        end
        apply(1, 1, 1, 0, 4'd0);
        apply(1, 0, 1, 0, 4'd0);
        apply(1, 0, 1, 0, 4'd0);
        apply(1, 1, 1, 0, 4'd0);
`ifdef CNTR_MOD_PRESCALE_EN
        check("c_phase_before", int'(count_c), 0);
`endif
        apply(1, 1, 1, 0, 4'd0);
`ifdef CNTR_MOD_PRESCALE_EN
        check("c_phase_step", int'(count_c), 1);
`endif
        apply(1, 1, 1, 0, 4'd0);
        apply(1, 0, 1, 1, 4'd2);
        check("c_load", int'(count_c), 2);
        apply(1, 1, 1, 0, 4'd0);
        apply(1, 1, 1, 0, 4'd0);
`ifdef CNTR_MOD_PRESCALE_EN
        check("c_load_wait", int'(count_c), 2);
`endif
        apply(1, 1, 1, 0, 4'd0);
`ifdef CNTR_MOD_PRESCALE_EN
        check("c_load_step", int'(count_c), 3);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic r, e, u, l;
            logic [3:0] lv;
            r  = ($urandom_range(0, 99) >= 3);
            e  = ($urandom_range(0, 99) < 70);
            u  = 1'($urandom_range(0, 1));
            l  = ($urandom_range(0, 99) < 10);
            lv = 4'($urandom_range(0, 15));
            apply(r, e, u, l, lv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cntr_mod.md
# cntr_mod

Parametrised synchronous modulo counter: the next generation of the basic 4-bit free-running counter. It adds configurable width and modulus, count enable, up/down direction, synchronous parallel load, and a registered wrap pulse, plus an optional compiled-in enable prescaler. It is used as the generic tick/index source for timers, display scanners and sequencers throughout the design.

## Interface
- WIDTH, 4: counter width in bits; legal range 1..16.
- MODULUS, 16: count range is 0..MODULUS-1; legal range 2..2**WIDTH; elaboration error otherwise.
- PRESCALE, 1: enable divisor, legal range 1..65536; used only when CNTR_MOD_PRESCALE_EN is defined.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-low; 0 at a rising clk edge resets the block.
- en  in  1  count enable; a step is requested on every enabled cycle.
- up  in  1  direction; 1 = increment, 0 = decrement; sampled each cycle.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  load value.
- count  out  WIDTH  current count, registered.
- wrap  out  1  one-cycle registered pulse, high in the cycle where count shows the wrapped value.

## Operation
- Priority at each rising edge: rst low > load > step > hold.
- Reset: count = 0, wrap = 0, prescaler = 0.
- Load: count = load_val if load_val <= MODULUS-1, else count = MODULUS-1 (clamp). Load sets wrap = 0, ignores en and up, and clears the prescaler.
- Step up: if count == MODULUS-1, count = 0 and wrap = 1; otherwise count + 1 and wrap = 0.
- Step down: if count == 0, count = MODULUS-1 and wrap = 1; otherwise count - 1 and wrap = 0.
- No step (en = 0, or prescaler not at terminal): count holds and wrap = 0.
- Arithmetic is unsigned in WIDTH bits. The count never leaves 0..MODULUS-1, including when MODULUS = 2**WIDTH (natural roll-over).
- Direction may change on any cycle with no penalty. A reversal at a boundary wraps only if the step itself crosses the boundary. Example: at count 0, an up step gives 1 with no wrap.
- rst low in mid-operation overrides load and en in the same cycle.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- Latency: one cycle. An input sampled at edge N appears on count and wrap after edge N.
- wrap is exactly one cycle wide per wrap event. With en held high, MODULUS = M and no prescaler, wrap pulses every M cycles.
- load followed by en in the next cycle: the step applies to the loaded value.
- After reset is released, the first step can occur at the first edge where rst = 1 and en = 1.

## Configuration
- CNTR_MOD_PRESCALE_EN defined:
  - An internal counter pre (0..PRESCALE-1) advances on each cycle with en = 1.
  - A step occurs only when en = 1 and pre == PRESCALE-1; pre then returns to 0.
  - pre is cleared by rst and by load, and holds when en = 0.
  - PRESCALE = 1 is equivalent to the macro being undefined.
- CNTR_MOD_PRESCALE_EN undefined: step = en; no prescaler logic is generated; PRESCALE is ignored.

## Test plan
- Reset and hold: WIDTH=4, MODULUS=16. Drive rst=0 for 2 cycles with en=1 -> count=0, wrap=0. Then rst=1, en=0 for 5 cycles -> count stays 0.
- Up wrap, non-power-of-2: MODULUS=10, up=1, en=1 for 12 cycles from 0 -> count 1..9, 0, 1, 2. wrap is high only in the cycle count=0 (the 10th cycle).
- Down wrap and reversal: MODULUS=10. Load 1, then up=0 for 2 steps -> 0, then 9 with wrap=1. Then up=1 for 1 step -> 0 with wrap=1.
- Load clamp and priority: MODULUS=10. Drive load=1 with load_val=13 and en=1 -> count=9, wrap=0. Drive rst=0 with load=1 in the same cycle -> count=0.
- Full-range roll-over: WIDTH=4, MODULUS=16, load 15, up step -> count=0, wrap=1. From 0, a down step -> count=15, wrap=1.
- Prescaler (macro defined, PRESCALE=3, MODULUS=4): en=1 continuously -> count advances every 3rd cycle and wrap pulses every 12 cycles. Drop en for 2 cycles mid-period -> the phase is preserved. Load mid-period -> the first step comes 3 enabled cycles later.
